// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 style memory/MMIO controller: FSM encoding,
// device register offsets and status bit positions.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MMIO_REGS = 4;

  localparam logic [1:0] KBDR_OFF = 2'd0;
  localparam logic [1:0] KBSR_OFF = 2'd1;
  localparam logic [1:0] DDR_OFF  = 2'd2;
  localparam logic [1:0] DSR_OFF  = 2'd3;

  // Ready bit of KBSR/DSR and interrupt-enable storage bit of KBSR.
  localparam int STATUS_BIT = 15;
  localparam int KB_IE_BIT  = 14;

endpackage

// File: rtl/lc3_ram.sv
// Word-addressed RAM: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module lc3_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_mmio_ctrl.sv
// Memory controller with wait-stated RAM and four memory-mapped keyboard and
// display registers; one access in flight, completion signalled by r.
module mem_mmio_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH       = 1024,
  parameter logic [ADDR_W-1:0] MMIO_BASE   = ADDR_W'(16'h03F0),
  parameter int                WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_en,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out,
  output logic              r,
  input  logic              kb_valid,
  input  logic [7:0]        kb_data,
  output logic              dsp_valid,
  output logic [7:0]        dsp_data,
  input  logic              dsp_ready
);

  // Handshakes: mem_en/rw/addr/data are sampled only in IDLE and ignored
  // until r has pulsed for its single DONE cycle; a display character moves
  // on the rising edge where dsp_valid and dsp_ready are both 1.

  localparam int RAM_AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] data_q;

  logic [7:0]        kbdr_q;
  logic              kb_rdy_q, kb_ie_q;
  logic [7:0]        ddr_q;
  logic              dsr_rdy_q, dsp_valid_q;

  logic              acc_mmio, acc_ram;
  logic [1:0]        reg_sel;
  logic [DATA_W-1:0] mmio_rdata, ram_rdata;
  logic              ram_we, kbdr_rd, kbsr_wr, ddr_wr;

  // MMIO decode has priority because the register window overlaps RAM.
  function automatic logic in_mmio(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - MMIO_BASE;
    return (a >= MMIO_BASE) && (off < ADDR_W'(MMIO_REGS));
  endfunction

  function automatic logic in_ram(input logic [ADDR_W-1:0] a);
    return !in_mmio(a) && (32'(a) < 32'(DEPTH));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (mem_en) begin
          wcnt_d = '0;
          if (in_mmio(addr) || WAIT_STATES == 0) state_d = DONE;
          else                                    state_d = WAIT;
        end
      end
      WAIT: begin
        if (wcnt_q == 4'(WAIT_STATES - 1)) state_d = DONE;
        else                               wcnt_d  = wcnt_q + 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rw_q   <= 1'b0;
      data_q <= '0;
    end else if (state_q == IDLE && mem_en) begin
      addr_q <= addr;
      rw_q   <= rw;
      data_q <= data;
    end
  end

  assign acc_mmio = in_mmio(addr_q);
  assign acc_ram  = in_ram(addr_q);
  assign reg_sel  = 2'(addr_q - MMIO_BASE);

  always_comb begin
    mmio_rdata = '0;
    case (reg_sel)
      KBDR_OFF: mmio_rdata[7:0] = kbdr_q;
      KBSR_OFF: begin
        mmio_rdata[STATUS_BIT] = kb_rdy_q;
        mmio_rdata[KB_IE_BIT]  = kb_ie_q;
      end
      DDR_OFF:  mmio_rdata[7:0] = ddr_q;
      DSR_OFF:  mmio_rdata[STATUS_BIT] = dsr_rdy_q;
      default:  mmio_rdata = '0;
    endcase
  end

  // Unmapped accesses fall through every branch: read 0, write dropped.
  always_comb begin
    out     = '0;
    ram_we  = 1'b0;
    kbdr_rd = 1'b0;
    kbsr_wr = 1'b0;
    ddr_wr  = 1'b0;
    if (state_q == DONE) begin
      if (acc_mmio) begin
        if (rw_q) begin
          kbsr_wr = (reg_sel == KBSR_OFF);
          ddr_wr  = (reg_sel == DDR_OFF);
        end else begin
          kbdr_rd = (reg_sel == KBDR_OFF);
          out     = mmio_rdata;
        end
      end else if (acc_ram) begin
        if (rw_q) ram_we = 1'b1;
        else      out    = ram_rdata;
      end
    end
  end

  // A keyboard strobe wins over the ready-clear of a coincident KBDR read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbdr_q   <= '0;
      kb_rdy_q <= 1'b0;
      kb_ie_q  <= 1'b0;
    end else begin
      if (kb_valid) begin
        kbdr_q   <= kb_data;
        kb_rdy_q <= 1'b1;
      end else if (kbdr_rd) begin
        kb_rdy_q <= 1'b0;
      end
      if (kbsr_wr) kb_ie_q <= data_q[KB_IE_BIT];
    end
  end

  // DSR ready is low exactly while a character is pending, so a DDR load
  // and a consumer handshake can never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ddr_q       <= '0;
      dsr_rdy_q   <= 1'b1;
      dsp_valid_q <= 1'b0;
    end else if (ddr_wr && dsr_rdy_q) begin
      ddr_q       <= data_q[7:0];
      dsr_rdy_q   <= 1'b0;
      dsp_valid_q <= 1'b1;
    end else if (dsp_valid_q && dsp_ready) begin
      dsr_rdy_q   <= 1'b1;
      dsp_valid_q <= 1'b0;
    end
  end

  assign r         = (state_q == DONE);
  assign dsp_valid = dsp_valid_q;
  assign dsp_data  = ddr_q;

  lc3_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (addr_q[RAM_AW-1:0]),
    .wdata(data_q),
    .rdata(ram_rdata)
  );

endmodule
